jsv_status_in: RTL and testbench

JSV_STATUS_IN -- requirements
Module: jsv_status_in

---
 rtl/jsv_pio_pkg.sv | 33 +++
 rtl/jsv_edge_detect.sv | 32 +++
 rtl/jsv_status_in.sv | 111 +++++++++++
 tb/tb_jsv_status_in.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jsv_pio_pkg.sv
// jsv_pio_pkg: shared constants, types and helpers for the status-input PIO.
// Register map addresses, port width and the edge-capture update rule.
package jsv_pio_pkg;

  // Width of the status input port (bit0 frame_done, bit1 busy)
  localparam int PIO_WIDTH = 2;

  // Avalon-MM data bus width
  localparam int DATA_W = 32;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // One-hot view of which writable register a bus write is aimed at
  typedef struct packed {
    logic irqmask;
    logic edgecap;
  } wr_sel_t;

  // Edge-capture update: clear the written ones first, then OR in new
  // rises so that a rise arriving in the clearing cycle is never lost.
  function automatic logic [PIO_WIDTH-1:0] capture_next(
    input logic [PIO_WIDTH-1:0] cur,
    input logic [PIO_WIDTH-1:0] clr,
    input logic [PIO_WIDTH-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/jsv_edge_detect.sv
// jsv_edge_detect: per-bit two-flop synchronizer, previous-value flop and
// rising-edge detect for one asynchronous status input.
module jsv_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic s1_reg;
  logic s2_reg;
  logic p_reg;

  // Synchronize the raw input and keep one cycle of synchronized history;
  // p clears on reset so a level held high across release still counts as a rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      p_reg  <= 1'b0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      p_reg  <= s2_reg;
    end
  end

  assign level = s2_reg;
  assign rise  = s2_reg & ~p_reg;

endmodule

// File: rtl/jsv_status_in.sv
// jsv_status_in: Avalon-MM status input PIO with edge capture and interrupt.
// Map: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAP (read, W1C).
// Optional feature macro: JSV_STATUS_IN_IRQ_EN. When undefined there is no
// IRQMASK storage, address 2 reads 0 and irq is tied low.
module jsv_status_in
  import jsv_pio_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [DATA_W-1:0]    writedata,
  input  logic [PIO_WIDTH-1:0] in_port,
  output logic [DATA_W-1:0]    readdata,
  output logic                 irq
);

  logic [PIO_WIDTH-1:0] level;
  logic [PIO_WIDTH-1:0] rise;
  logic [PIO_WIDTH-1:0] edgecap_reg;
  logic [PIO_WIDTH-1:0] edgecap_next;
  logic [PIO_WIDTH-1:0] mask_value;
  wr_sel_t              wr_sel;
  logic                 unused_writedata;

  // Only the low PIO_WIDTH bits of a write carry register content
  assign unused_writedata = ^writedata[DATA_W-1:PIO_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < PIO_WIDTH; gi++) begin : g_bit
      jsv_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (in_port[gi]),
        .level   (level[gi]),
        .rise    (rise[gi])
      );
    end
  endgenerate

  // Decode which register, if any, the current bus write targets
  always_comb begin
    wr_sel = '0;
    if (chipselect && !write_n) begin
      wr_sel.irqmask = (address == ADDR_IRQMASK);
      wr_sel.edgecap = (address == ADDR_EDGECAP);
    end
  end

  // Edge-capture next state: write-1-to-clear, with new rises winning
  always_comb begin
    edgecap_next = capture_next(edgecap_reg,
                                wr_sel.edgecap ? writedata[PIO_WIDTH-1:0] : '0,
                                rise);
  end

  // Edge-capture register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_reg <= '0;
    end else begin
      edgecap_reg <= edgecap_next;
    end
  end

`ifdef JSV_STATUS_IN_IRQ_EN
  logic [PIO_WIDTH-1:0] mask_reg;
  logic [PIO_WIDTH-1:0] mask_next;

  // Interrupt mask next state: plain read/write register
  always_comb begin
    mask_next = mask_reg;
    if (wr_sel.irqmask) begin
      mask_next = writedata[PIO_WIDTH-1:0];
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end

  assign mask_value = mask_reg;
  // Level interrupt straight from registers, no added latency
  assign irq = |(edgecap_reg & mask_reg);
`else
  logic unused_irqmask_sel;

  assign unused_irqmask_sel = wr_sel.irqmask;
  assign mask_value         = '0;
  assign irq                = 1'b0;
`endif

  // Zero-wait-state read mux with no side effects
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[PIO_WIDTH-1:0] = level;
      ADDR_IRQMASK: readdata[PIO_WIDTH-1:0] = mask_value;
      ADDR_EDGECAP: readdata[PIO_WIDTH-1:0] = edgecap_reg;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_jsv_status_in.sv
// tb_jsv_status_in: randomized and directed bench for jsv_status_in with a
// sample-history reference model. Honours JSV_STATUS_IN_IRQ_EN when defined.
module tb_jsv_status_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int txn   = 0;

  // Reference model: input samples taken at each clock edge since reset
  logic [1:0] hist[$];
  logic [1:0] m_ecap;
  logic [1:0] m_mask;

`ifdef JSV_STATUS_IN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  jsv_status_in dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample taken b edges ago (1 = most recent); zero before reset release
  function automatic logic [1:0] back(input int b);
    if (hist.size() >= b) return hist[hist.size() - b];
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {30'b0, back(2)};
      2'd2:    return {30'b0, m_mask};
      2'd3:    return {30'b0, m_ecap};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_irq();
    return |(m_ecap & m_mask);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Drive one bus cycle at the falling edge and compare against the model
  task automatic drive(input logic [1:0] inp, input logic [1:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd);
    @(negedge clk);
    in_port    = inp;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    #1;
    check("model_rd", readdata, exp_rd(a));
    check("model_irq", 32'(irq), 32'(exp_irq()));
    txn++;
    $display("txn %0d: in=%b addr=%0d cs=%0b wn=%0b wd=%08h rd=%08h irq=%0b",
             txn, inp, a, cs, wn, wd, readdata, irq);
  endtask

  // Advance the model across one rising edge
  task automatic tick();
    logic [1:0] rise;
    logic [1:0] clr;
    @(posedge clk);
    if (reset_n) begin
      rise = back(2) & ~back(3);
      clr  = (chipselect && !write_n && address == 2'd3) ? writedata[1:0] : 2'b00;
      if (IRQ_ON && chipselect && !write_n && address == 2'd2) m_mask = writedata[1:0];
      m_ecap = (m_ecap & ~clr) | rise;
      hist.push_back(in_port);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  endtask

  task automatic step(input logic [1:0] inp, input logic [1:0] a, input logic cs,
                      input logic wn, input logic [31:0] wd);
    drive(inp, a, cs, wn, wd);
    tick();
  endtask

  task automatic rd(input logic [1:0] inp, input logic [1:0] a);
    step(inp, a, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic wr(input logic [1:0] inp, input logic [1:0] a, input logic [31:0] d);
    step(inp, a, 1'b1, 1'b0, d);
  endtask

  // Assert reset between edges, check immediate clearing, release on a falling edge
  task automatic do_reset(input logic [1:0] inp, input int hold);
    @(negedge clk);
    reset_n    = 1'b0;
    in_port    = inp;
    chipselect = 1'b0;
    write_n    = 1'b1;
    #1;
    hist.delete();
    m_ecap = 2'b00;
    m_mask = 2'b00;
    for (int a = 0; a < 4; a++) begin
      address = a[1:0];
      #1;
      check("reset_rd", readdata, 32'h0);
    end
    check("reset_irq", 32'(irq), 32'h0);
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [1:0]  cur_in;
    logic [1:0]  r_addr;
    logic        r_cs;
    logic        r_wn;
    logic [31:0] r_wd;

    reset_n    = 1'b1;
    in_port    = 2'b00;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    m_ecap     = 2'b00;
    m_mask     = 2'b00;

    // Reset state on all addresses
    do_reset(2'b00, 2);
    repeat (3) rd(2'b00, 2'd0);

    // Bit-0 rise: DATA after edge k+1, EDGECAP after edge k+2, irq masked
    drive(2'b01, 2'd0, 1'b1, 1'b1, 32'h0); tick();
    drive(2'b01, 2'd0, 1'b1, 1'b1, 32'h0); check("data_before_k1", readdata, 32'h0); tick();
    drive(2'b01, 2'd0, 1'b1, 1'b1, 32'h0); check("data_after_k1", readdata, 32'h1); tick();
    drive(2'b01, 2'd3, 1'b1, 1'b1, 32'h0); check("ecap_after_k2", readdata, 32'h1);
    check("irq_masked", 32'(irq), 32'h0); tick();

    // Unmask, clear, raise bit 1, then clear it by W1C
    wr(2'b01, 2'd2, 32'h3);
    wr(2'b01, 2'd3, 32'h3);
    drive(2'b11, 2'd1, 1'b1, 1'b1, 32'h0); check("rsvd_reads_0", readdata, 32'h0); tick();
    drive(2'b11, 2'd1, 1'b1, 1'b1, 32'h0); tick();
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("irq_before_k2", 32'(irq), 32'h0); tick();
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("irq_at_k2", 32'(irq), 32'(IRQ_ON));
    check("ecap_bit1", readdata, 32'h2); tick();
    wr(2'b11, 2'd3, 32'h2);
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("irq_cleared", 32'(irq), 32'h0);
    check("ecap_cleared", readdata, 32'h0); tick();

    // Clear in the same cycle as a new bit-0 rise: set wins
    repeat (3) rd(2'b10, 2'd0);
    drive(2'b11, 2'd0, 1'b1, 1'b1, 32'h0); tick();
    drive(2'b11, 2'd0, 1'b1, 1'b1, 32'h0); tick();
    drive(2'b11, 2'd3, 1'b1, 1'b0, 32'h1); tick();
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("set_wins", readdata, 32'h1); tick();
    wr(2'b11, 2'd3, 32'h0);
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("write0_keeps", readdata, 32'h1); tick();
    wr(2'b11, 2'd0, 32'h0);
    drive(2'b11, 2'd0, 1'b1, 1'b1, 32'h0); check("data_write_ignored", readdata, 32'h3); tick();

    // Mask readback and irq with a pending bit 0
    wr(2'b11, 2'd2, 32'h3);
    drive(2'b11, 2'd2, 1'b1, 1'b1, 32'h0); check("mask_readback", readdata, IRQ_ON ? 32'h3 : 32'h0);
    check("irq_pending", 32'(irq), 32'(IRQ_ON)); tick();

    // Level held high through reset release, then a one-cycle low glitch
    do_reset(2'b11, 2);
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("held_edge2", readdata, 32'h0); tick();
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("held_edge3_pre", readdata, 32'h0); tick();
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("held_capture", readdata, 32'h3); tick();
    wr(2'b11, 2'd3, 32'h3);
    rd(2'b00, 2'd3);
    repeat (5) rd(2'b11, 2'd3);
    drive(2'b11, 2'd3, 1'b1, 1'b1, 32'h0); check("glitch_once", readdata, 32'h3); tick();

    // Randomized traffic with occasional resets
    cur_in = 2'b11;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(2'($urandom_range(0, 3)), 1 + int'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 2) == 0) cur_in = cur_in ^ 2'($urandom_range(0, 3));
      r_addr = 2'($urandom_range(0, 3));
      r_cs   = ($urandom_range(0, 3) != 0);
      r_wn   = 1'($urandom_range(0, 1));
      r_wd   = $urandom;
      step(cur_in, r_addr, r_cs, r_wn, r_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
